// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS-lite sequencer: fetch/decode/execute/mem/write-back over shared ALU and one memory port.
// Latency: lw 5, sw/R/ori 4, beq/j 3 cycles; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one.
// Backpressure: mem_ready stalls FETCH/MEMRD/MEMWR; optional jump support via `define MIPS_JUMP_EN.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       instr_done,
  output logic       trap,
  output logic [3:0] state
);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ORI = 6'b001101;
`ifdef MIPS_JUMP_EN
  localparam logic [5:0] OP_J   = 6'b000010;
`endif

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  // Moore part of the control word; mem_ready-gated strobes are added on the output side.
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       done;
    logic       trap;
  } ctl_t;

  state_t r_state;
  ctl_t   r_ctl;
  state_t w_next;
  logic   w_in_fetch;
  logic   w_in_memwr;

  function automatic state_t next_of(input state_t s, input logic [5:0] op, input logic rdy);
    state_t n;
    n = S_TRAP;
    case (s)
      S_IDLE:   n = S_FETCH;
      S_FETCH:  n = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_R:         n = S_REXEC;
          OP_BEQ:       n = S_BRANCH;
          OP_ORI:       n = S_IEXEC;
`ifdef MIPS_JUMP_EN
          OP_J:         n = S_JUMP;
`endif
          default:      n = S_TRAP;
        endcase
      end
      // IR cannot change after DECODE, so anything but lw/sw here is unreachable.
      S_MEMADR: n = (op == OP_LW) ? S_MEMRD : ((op == OP_SW) ? S_MEMWR : S_TRAP);
      S_MEMRD:  n = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  n = rdy ? S_FETCH : S_MEMWR;
      S_REXEC:  n = S_RWB;
      S_IEXEC:  n = S_IWB;
      S_MEMWB, S_RWB, S_BRANCH, S_IWB, S_JUMP: n = S_FETCH;
      default:  n = S_TRAP;
    endcase
    return n;
  endfunction

  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.memread = 1'b1; c.alusrcb = 2'b01; end
      S_DECODE: c.alusrcb = 2'b11;
      S_MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:  begin c.memread = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.done = 1'b1; end
      S_MEMWR:  begin c.memwrite = 1'b1; c.iord = 1'b1; end
      S_REXEC:  begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      S_RWB:    begin c.regwrite = 1'b1; c.regdst = 1'b1; c.done = 1'b1; end
      S_BRANCH: begin
        c.alusrca = 1'b1; c.aluop = 2'b01; c.pcwritecond = 1'b1;
        c.pcsource = 2'b01; c.done = 1'b1;
      end
      S_IEXEC:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.zeroext = 1'b1; c.aluop = 2'b11; end
      S_IWB:    begin c.regwrite = 1'b1; c.done = 1'b1; end
`ifdef MIPS_JUMP_EN
      S_JUMP:   begin c.pcwrite = 1'b1; c.pcsource = 2'b10; c.done = 1'b1; end
`endif
      S_TRAP:   c.trap = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  assign w_next = next_of(r_state, opcode, mem_ready);

  // State register plus control word registered from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ctl   <= '0;
    end else begin
      r_state <= w_next;
      r_ctl   <= ctl_of(w_next);
    end
  end

  assign w_in_fetch = (r_state == S_FETCH);
  assign w_in_memwr = (r_state == S_MEMWR);

  // IR/PC load and sw retire only happen on the cycle memory completes.
  assign irwrite     = w_in_fetch & mem_ready;
  assign pcwrite     = r_ctl.pcwrite | (w_in_fetch & mem_ready);
  assign instr_done  = r_ctl.done | (w_in_memwr & mem_ready);
  assign pcwritecond = r_ctl.pcwritecond;
  assign iord        = r_ctl.iord;
  assign memread     = r_ctl.memread;
  assign memwrite    = r_ctl.memwrite;
  assign memtoreg    = r_ctl.memtoreg;
  assign regdst      = r_ctl.regdst;
  assign regwrite    = r_ctl.regwrite;
  assign alusrca     = r_ctl.alusrca;
  assign alusrcb     = r_ctl.alusrcb;
  assign zeroext     = r_ctl.zeroext;
  assign aluop       = r_ctl.aluop;
  assign trap        = r_ctl.trap;
  assign state       = r_state;
`ifdef MIPS_JUMP_EN
  assign pcsource    = r_ctl.pcsource;
`else
  assign pcsource    = r_ctl.pcsource & 2'b01;
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: directed instructions plus a random instruction mix
// with random mem_ready stalls, checked cycle by cycle against per-instruction step lists.
// Also covers illegal-opcode trap, async reset recovery and reset mid-store.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, zeroext, instr_done, trap;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext), .aluop(aluop),
    .pcsource(pcsource), .instr_done(instr_done), .trap(trap), .state(state)
  );

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       instr_done;
    logic       trap;
  } outs_t;

  outs_t obs;
  assign obs = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                regdst, regwrite, alusrca, alusrcb, zeroext, aluop, pcsource,
                instr_done, trap};

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  int total = 0;
  int bad   = 0;

  // One clock cycle: apply mem_ready, sample on the falling edge, compare.
  task automatic step(input logic [3:0] es, input outs_t eo, input logic mr);
    mem_ready = mr;
    @(negedge clk);
    total++;
    assert (state === es) else begin
      bad++;
      $error("FAIL state obs=%0d exp=%0d", state, es);
    end
    total++;
    assert (obs === eo) else begin
      bad++;
      $error("FAIL outs in_state=%0d obs=%b exp=%b", es, obs, eo);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected behaviour of one instruction, from its first FETCH cycle to retirement.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    outs_t e;
    logic  is_jump;
`ifdef MIPS_JUMP_EN
    is_jump = (op == OP_J);
`else
    is_jump = 1'b0;
`endif
    for (int i = 0; i < fw; i++) begin
      opcode = 6'($urandom);
      e = '0; e.memread = 1'b1; e.alusrcb = 2'b01;
      step(4'd1, e, 1'b0);
    end
    e = '0; e.memread = 1'b1; e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcwrite = 1'b1;
    step(4'd1, e, 1'b1);
    opcode = op;
    e = '0; e.alusrcb = 2'b11;
    step(4'd2, e, rbit());
    if (op == OP_LW) begin
      e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
      step(4'd3, e, rbit());
      e = '0; e.memread = 1'b1; e.iord = 1'b1;
      for (int i = 0; i < mw; i++) step(4'd4, e, 1'b0);
      step(4'd4, e, 1'b1);
      e = '0; e.regwrite = 1'b1; e.memtoreg = 1'b1; e.instr_done = 1'b1;
      step(4'd5, e, rbit());
    end else if (op == OP_SW) begin
      e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
      step(4'd3, e, rbit());
      e = '0; e.memwrite = 1'b1; e.iord = 1'b1;
      for (int i = 0; i < mw; i++) step(4'd6, e, 1'b0);
      e.instr_done = 1'b1;
      step(4'd6, e, 1'b1);
    end else if (op == OP_R) begin
      e = '0; e.alusrca = 1'b1; e.aluop = 2'b10;
      step(4'd7, e, rbit());
      e = '0; e.regwrite = 1'b1; e.regdst = 1'b1; e.instr_done = 1'b1;
      step(4'd8, e, rbit());
    end else if (op == OP_BEQ) begin
      e = '0; e.alusrca = 1'b1; e.aluop = 2'b01; e.pcwritecond = 1'b1;
      e.pcsource = 2'b01; e.instr_done = 1'b1;
      step(4'd9, e, rbit());
    end else if (op == OP_ORI) begin
      e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10; e.zeroext = 1'b1; e.aluop = 2'b11;
      step(4'd10, e, rbit());
      e = '0; e.regwrite = 1'b1; e.instr_done = 1'b1;
      step(4'd11, e, rbit());
    end else if (is_jump) begin
      e = '0; e.pcwrite = 1'b1; e.pcsource = 2'b10; e.instr_done = 1'b1;
      step(4'd12, e, rbit());
    end else begin
      e = '0; e.trap = 1'b1;
      for (int i = 0; i < 4; i++) begin
        opcode = 6'($urandom);
        step(4'd13, e, rbit());
      end
    end
  endtask

  // Async reset between clock edges, then release into one IDLE cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    total++;
    assert (state === 4'd0) else begin
      bad++;
      $error("FAIL reset_state obs=%0d exp=0", state);
    end
    total++;
    assert (obs === outs_t'('0)) else begin
      bad++;
      $error("FAIL reset_outs obs=%b exp=0", obs);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'd0, '0, rbit());
  endtask

  initial begin
    logic [5:0] legal [$];
    outs_t      e;
    mem_ready = 1'b0;
    opcode    = 6'd0;
    legal = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ORI};
`ifdef MIPS_JUMP_EN
    legal.push_back(OP_J);
`endif
    #2;
    do_reset();

    // Directed instructions from the test plan.
    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 0, 2);
    run_instr(OP_SW, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_ORI, 1, 0);
    run_instr(OP_SW, 2, 1);

    // Random instruction mix with random stalls.
    for (int n = 0; n < 40; n++) begin
      run_instr(legal[$urandom_range(0, legal.size() - 1)],
                $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Illegal opcode traps until reset.
    run_instr(OP_BAD, 0, 0);
    do_reset();
    // Jump: retires when enabled, traps otherwise.
    run_instr(OP_J, 0, 0);
    do_reset();
    run_instr(OP_ORI, 0, 0);

    // Reset in the middle of a stalled store.
    e = '0; e.memread = 1'b1; e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcwrite = 1'b1;
    step(4'd1, e, 1'b1);
    opcode = OP_SW;
    e = '0; e.alusrcb = 2'b11;
    step(4'd2, e, 1'b1);
    e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
    step(4'd3, e, 1'b1);
    mem_ready = 1'b0;
    @(negedge clk);
    total++;
    assert (memwrite === 1'b1) else begin
      bad++;
      $error("FAIL memwr_wait memwrite obs=%b exp=1", memwrite);
    end
    #2;
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    total++;
    assert (memwrite === 1'b0) else begin
      bad++;
      $error("FAIL midreset memwrite obs=%b exp=0", memwrite);
    end
    total++;
    assert (state === 4'd0) else begin
      bad++;
      $error("FAIL midreset state obs=%0d exp=0", state);
    end
    total++;
    assert (instr_done === 1'b0) else begin
      bad++;
      $error("FAIL midreset instr_done obs=%b exp=0", instr_done);
    end
    @(posedge clk);
    #1;
    total++;
    assert (obs === outs_t'('0)) else begin
      bad++;
      $error("FAIL reset_held outs obs=%b exp=0", obs);
    end
    rst_n = 1'b1;
    step(4'd0, '0, 1'b1);
    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle sequencer for the MIPS-lite datapath: a Moore/Mealy FSM that splits each instruction into fetch, decode, execute, memory and write-back steps over a shared ALU and a single unified memory port. Supports R-format, lw, sw, beq and ori, with j as an optional build feature. Takes the IR opcode and a memory-ready handshake. Drives every datapath mux select and write strobe, plus a retire pulse and a sticky illegal-opcode trap.

## Interface
- No parameters. Opcodes are fixed:
  - R-format 000000, lw 100011, sw 101011, beq 000100, ori 001101, j 000010.
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory has completed the current read/write this cycle
- pcwrite  out  1  unconditional PC load
- pcwritecond  out  1  PC load if ALU zero
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memread, memwrite  out  1 each  memory strobes
- irwrite  out  1  IR load
- memtoreg  out  1  write-back data select: 1 = MDR
- regdst  out  1  destination register select: 1 = rd, 0 = rt
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B select: 00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
- zeroext  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend
- aluop  out  2  ALU op: 00 add, 01 sub, 10 funct, 11 or
- pcsource  out  2  PC source: 00 ALU, 01 ALUOut, 10 jump target
- instr_done  out  1  one-cycle retire pulse
- trap  out  1  sticky illegal-opcode flag
- state  out  4  current state, for debug

## Operation
- State encoding:
  - IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, REXEC=7,
  - RWB=8, BRANCH=9, IEXEC=10, IWB=11, JUMP=12, TRAP=13.
- All outputs not listed for a state are 0.
- IDLE: no outputs. Goes to FETCH unconditionally.
- FETCH:
  - Outputs: memread=1, alusrcb=01.
  - Gated by mem_ready: irwrite=mem_ready, pcwrite=mem_ready (combinational).
  - Stays in FETCH while !mem_ready; goes to DECODE when mem_ready=1.
- DECODE: alusrcb=11 (branch target into ALUOut). Next state by opcode:
  - lw or sw -> MEMADR
  - R-format -> REXEC
  - beq -> BRANCH
  - ori -> IEXEC
  - j -> JUMP (only when enabled, see Configuration)
  - anything else -> TRAP
- MEMADR: alusrca=1, alusrcb=10. lw -> MEMRD; sw -> MEMWR.
- MEMRD: memread=1, iord=1. Waits for mem_ready, then -> MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Retires.
- MEMWR: memwrite=1, iord=1. Waits for mem_ready, then retires.
- REXEC: alusrca=1, alusrcb=00, aluop=10. Goes to RWB.
- RWB: regwrite=1, regdst=1. Retires.
- BRANCH: alusrca=1, aluop=01, pcwritecond=1, pcsource=01. Retires.
- IEXEC: alusrca=1, alusrcb=10, zeroext=1, aluop=11. Goes to IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0. Retires.
- JUMP: pcwrite=1, pcsource=10. Retires.
- Retire: next state is FETCH, and instr_done=1 during the retiring state's cycle.
- TRAP:
  - trap=1; all strobes 0; absorbing state.
  - Only rst_n leaves TRAP.

## Timing
- Reset:
  - rst_n low forces state=IDLE immediately, without waiting for a clock edge.
  - Every output is then 0, and state=0.
  - First rising edge with rst_n high enters FETCH.
- Cycle counts with mem_ready held 1:
  - lw = 5 cycles; sw, R-format, ori = 4; beq, j = 3.
  - Each wait cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- Strobe behaviour:
  - memread and memwrite stay high for the whole wait.
  - A write strobe (irwrite, pcwrite, regwrite, pcwritecond) is never high in a cycle that repeats.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- opcode is sampled only in DECODE and MEMADR. The IR is stable there because irwrite=0.
- instr_done is high exactly one cycle per instruction, coincident with the last state.
- Reset mid-instruction aborts it with no further strobes. No instr_done is produced.

## Configuration
- MIPS_JUMP_EN defined:
  - Opcode 000010 decodes to JUMP, which is 3 cycles and sets pcsource=10.
- MIPS_JUMP_EN undefined:
  - State 12 is unreachable and opcode 000010 goes to TRAP.
  - pcsource[1] is tied to 0.

## Test plan
- Reset then R-format, opcode=000000, mem_ready=1:
  - state sequence 0,1,2,7,8,1.
  - RWB has regwrite=1, regdst=1; instr_done high 1 cycle.
- lw, opcode=100011, with mem_ready=0 for 2 cycles in MEMRD:
  - 7 cycles total.
  - memread and iord held high during the wait.
  - MEMWB has regwrite=1, memtoreg=1.
- sw 101011 followed by beq 000100:
  - memwrite=1 only in MEMWR.
  - BRANCH has pcwritecond=1, aluop=01, pcsource=01.
  - Total 4+3 cycles.
- ori 001101:
  - IEXEC has aluop=11, zeroext=1, alusrcb=10.
  - IWB has regwrite=1, regdst=0.
- Opcode 111111 (and 000010 without MIPS_JUMP_EN):
  - trap=1 from the cycle after DECODE, and remains 1 under any mem_ready.
  - Deassert rst_n and re-release: trap=0, state enters FETCH.
- rst_n pulled low mid-MEMWR without a clock edge:
  - memwrite drops at once and state=0.
  - No instr_done.
